sample_packer: RTL and testbench
================================

# sample_packer

Packs variable-width compacted samples into full DW-bit words for the capture memory. Sits directly downstream of the channel-compacting shifter: that stage delivers each sample with its enabled byte groups compacted into the low bytes. This block concatenates those bytes across sample boundaries and emits only dense words. It supports backpressure, a flush of the partial tail word, and synchronous clear.

## Interface
- DW, 32: data width in bits; multiple of 8. BW = DW/8 byte lanes.
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ctl_clr  in  1  synchronous clear of all pack state; also loads the configuration
- ctl_ena  in  1  stage enable; low freezes all state
- ctl_flush  in  1  single-cycle request to emit the partial tail word
- cfg_mask  in  BW  enabled byte groups; N = popcount, with 0 treated as BW
- sti_data  in  DW  compacted sample; low N bytes valid, upper bytes ignored
- sti_valid  in  1  input valid
- sti_ready  out  1  input ready
- sto_data  out  DW  packed word
- sto_valid  out  1  output valid
- sto_ready  in  1  output ready
- sto_last  out  1  present only with SAMPLE_PACKER_LAST_EN; marks the flush word

## Operation
- Registered N (cfg_n, range 1..BW) is loaded from cfg_mask on ctl_clr and on rst (at rst, cfg_n=BW).
- State: fill (0..BW-1 pending bytes) and pend (BW-1 bytes, byte-aligned, lowest byte = oldest).
- Accept condition: sti_valid & sti_ready & ctl_ena.
- On accept:
  - cat = pend | (sample_low_N_bytes << 8*fill).
  - nf = fill + N (max 2BW-1).
  - If nf >= BW: load the output register with cat[DW-1:0], set pend = cat >> DW, set fill = nf - BW.
  - Otherwise: pend = cat, fill = nf.
- Byte order: the first byte received lands in sto_data[7:0].
- Output: one-deep register. sti_ready = ctl_ena & (state==RUN) & (~sto_valid | sto_ready).
- FSM states:
  - RUN: normal packing. ctl_flush moves to FLUSH.
  - FLUSH: sti_ready=0. When the output slot is free (~sto_valid | sto_ready):
    - fill>0: emit pend zero-padded, set fill=0, go to DONE.
    - fill==0: emit nothing, go to DONE. With LAST_EN, emit an all-zero word with sto_last=1 instead.
  - DONE: sti_ready=0; any remaining output drains. Leave only on ctl_clr → RUN.
- Simultaneous accept and ctl_flush in the same cycle: the sample is packed first, and the flush then operates on the updated fill and pend.
- ctl_flush in FLUSH or DONE is ignored.
- Priority: rst > ctl_clr > ctl_ena gating > flush and accept.
- ctl_clr sets fill=0, pend=0, sto_valid=0, state=RUN. Any word held in the output register is discarded.
- ctl_ena=0: no state changes, sti_ready=0, sto_valid and sto_data held.

## Timing
- Reset values: sto_valid=0, sto_data=0, sti_ready=0 while rst is high, state=RUN, fill=0, pend=0, sto_last=0.
- Latency: the word is valid in the cycle after the accept that completes it (1 clk).
- N=BW gives full throughput: one word per cycle with sto_ready held high.
- No combinational path from sti_valid to sto_valid. sti_ready depends combinationally on sto_ready.
- sto_data and sto_valid (and sto_last) are stable while sto_valid=1 and sto_ready=0.
- Asserting rst mid-word drops all pending bytes asynchronously.

## Configuration
- SAMPLE_PACKER_LAST_EN defined:
  - The sto_last port exists and is high only with the flush word.
  - A flush with fill==0 emits one zero word with sto_last=1, so the consumer always sees a terminator.
- Not defined:
  - No sto_last port.
  - A flush with fill==0 produces no output.
- In both cases, packing of full words is identical.

## Structure
- Shared package holds:
  - the FSM state enum {RUN, FLUSH, DONE};
  - the BW localparam function;
  - a popcount function used for cfg_n.
- One sub-module, byte_merge: the combinational computation of cat, nf and the word/pend split from pend, fill, sample and N. It is instantiated once. The FSM and registers stay in sample_packer.

## Test plan
- N=1 (cfg_mask=0001), samples 0x11, 0x22, 0x33, 0x44 → one word 0x44332211, valid 1 clk after the 4th accept.
- N=3 (cfg_mask=0111), samples 0x00CCBBAA and 0x00FFEEDD → word 0xDDCCBBAA, fill=2; then ctl_flush → 0x0000FFEE (sto_last=1 with LAST_EN), state DONE, sti_ready=0.
- N=4, continuous valid, sto_ready=1 → each sample appears unchanged 1 clk later, one word per clk. Hold sto_ready=0 for 3 clk → sti_ready=0 and sto_data stable.
- N=2, accept 0xBBAA with ctl_flush in the same cycle → sample packed, flush emits 0x0000BBAA. A flush with fill==0 emits nothing (or a zero word with sto_last=1 under LAST_EN).
- N=3, after 1 sample assert ctl_clr → fill=0, sto_valid=0. Next 4 samples 0x030201, 0x060504, 0x090807, 0x0C0B0A → words 0x04030201, 0x08070605, 0x0C0B0A09.
- rst pulse mid-word and ctl_ena=0 for 2 clk mid-stream → all outputs at reset values after rst; no state change during ctl_ena=0.

Source files
------------

// File: rtl/sample_packer_pkg.sv
// Shared types and helpers for the sample packer: FSM states, lane count, popcount.
package sample_packer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int unsigned bw_of(input int unsigned dw);
        return dw / 8;
    endfunction

    // Callers zero-extend the mask to 64 bits.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            cnt = cnt + {31'b0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sample_packer_byte_merge.sv
// Combinational merge of one compacted sample into the pending bytes, splitting
// off a full output word when enough bytes have accumulated.
module sample_packer_byte_merge
    import sample_packer_pkg::*;
#(
    parameter  int unsigned DW  = 32,
    localparam int unsigned BW  = bw_of(DW),
    localparam int unsigned PW  = DW - 8,
    localparam int unsigned CW  = 2 * DW - 8,
    localparam int unsigned FW  = $clog2(BW),
    localparam int unsigned NW  = $clog2(BW + 1),
    localparam int unsigned NFW = $clog2(2 * BW)
) (
    input  logic [PW-1:0] pend_i,
    input  logic [FW-1:0] fill_i,
    input  logic [DW-1:0] sample_i,
    input  logic [NW-1:0] n_i,
    output logic          full_o,
    output logic [DW-1:0] word_o,
    output logic [PW-1:0] pend_o,
    output logic [FW-1:0] fill_o
);

    logic [DW-1:0]  byte_mask;
    logic [DW-1:0]  masked;
    logic [CW-1:0]  cat;
    logic [NFW-1:0] nf;

    always_comb begin
        byte_mask = '0;
        for (int unsigned i = 0; i < BW; i++) begin
            if (i < 32'(n_i)) begin
                byte_mask[8*i +: 8] = 8'hFF;
            end
        end
        masked = sample_i & byte_mask;
        cat    = CW'(pend_i) | (CW'(masked) << {fill_i, 3'b000});
        nf     = NFW'(fill_i) + NFW'(n_i);
        full_o = (nf >= NFW'(BW));
        word_o = cat[DW-1:0];
        if (full_o) begin
            pend_o = cat[CW-1:DW];
            fill_o = FW'(nf - NFW'(BW));
        end else begin
            pend_o = cat[PW-1:0];
            fill_o = FW'(nf);
        end
    end

endmodule

// File: rtl/sample_packer.sv
// Packs variable-width compacted samples into dense DW-bit words with flush and clear.
// Optional SAMPLE_PACKER_LAST_EN adds sto_last and a zero terminator word on empty flush.
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter  int unsigned DW = 32,
    localparam int unsigned BW = bw_of(DW),
    localparam int unsigned PW = DW - 8,
    localparam int unsigned FW = $clog2(BW),
    localparam int unsigned NW = $clog2(BW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_clr,
    input  logic          ctl_ena,
    input  logic          ctl_flush,
    input  logic [BW-1:0] cfg_mask,
    input  logic [DW-1:0] sti_data,
    input  logic          sti_valid,
    output logic          sti_ready,
    output logic [DW-1:0] sto_data,
    output logic          sto_valid,
`ifdef SAMPLE_PACKER_LAST_EN
    output logic          sto_last,
`endif
    input  logic          sto_ready
);

    state_e        state_q, state_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [PW-1:0] pend_q, pend_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic [NW-1:0] cfg_n_q, cfg_n_d;
`ifdef SAMPLE_PACKER_LAST_EN
    logic          last_q, last_d;
`endif

    logic          slot_free;
    logic          accept;
    logic [NW-1:0] mask_cnt;
    logic          m_full;
    logic [DW-1:0] m_word;
    logic [PW-1:0] m_pend;
    logic [FW-1:0] m_fill;

    assign slot_free = ~valid_q | sto_ready;
    assign sti_ready = ~rst & ctl_ena & (state_q == ST_RUN) & slot_free;
    assign accept    = sti_valid & sti_ready;
    assign mask_cnt  = NW'(popcount(64'(cfg_mask)));

    assign sto_data  = data_q;
    assign sto_valid = valid_q;
`ifdef SAMPLE_PACKER_LAST_EN
    assign sto_last  = last_q;
`endif

    sample_packer_byte_merge #(.DW(DW)) u_merge (
        .pend_i   (pend_q),
        .fill_i   (fill_q),
        .sample_i (sti_data),
        .n_i      (cfg_n_q),
        .full_o   (m_full),
        .word_o   (m_word),
        .pend_o   (m_pend),
        .fill_o   (m_fill)
    );

    // Next-state: clear wins over enable; a flush acts on the post-accept fill/pend.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        pend_d  = pend_q;
        data_d  = data_q;
        valid_d = valid_q;
        cfg_n_d = cfg_n_q;
`ifdef SAMPLE_PACKER_LAST_EN
        last_d  = last_q;
`endif
        if (ctl_clr) begin
            state_d = ST_RUN;
            fill_d  = '0;
            pend_d  = '0;
            valid_d = 1'b0;
            cfg_n_d = (mask_cnt == '0) ? NW'(BW) : mask_cnt;
`ifdef SAMPLE_PACKER_LAST_EN
            last_d  = 1'b0;
`endif
        end else if (ctl_ena) begin
            if (valid_q && sto_ready) begin
                valid_d = 1'b0;
`ifdef SAMPLE_PACKER_LAST_EN
                last_d  = 1'b0;
`endif
            end
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        fill_d = m_fill;
                        pend_d = m_pend;
                        if (m_full) begin
                            data_d  = m_word;
                            valid_d = 1'b1;
`ifdef SAMPLE_PACKER_LAST_EN
                            last_d  = 1'b0;
`endif
                        end
                    end
                    if (ctl_flush) begin
                        state_d = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (slot_free) begin
                        state_d = ST_DONE;
                        if (fill_q != '0) begin
                            data_d  = DW'(pend_q);
                            valid_d = 1'b1;
                            fill_d  = '0;
                            pend_d  = '0;
`ifdef SAMPLE_PACKER_LAST_EN
                            last_d  = 1'b1;
`endif
                        end
`ifdef SAMPLE_PACKER_LAST_EN
                        else begin
                            data_d  = '0;
                            valid_d = 1'b1;
                            last_d  = 1'b1;
                        end
`endif
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            fill_q  <= '0;
            pend_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cfg_n_q <= NW'(BW);
`ifdef SAMPLE_PACKER_LAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cfg_n_q <= cfg_n_d;
`ifdef SAMPLE_PACKER_LAST_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_sample_packer.sv
// Directed self-checking bench for sample_packer (DW=32), honours SAMPLE_PACKER_LAST_EN.
module tb_sample_packer;

    logic        clk;
    logic        rst;
    logic        ctl_clr;
    logic        ctl_ena;
    logic        ctl_flush;
    logic [3:0]  cfg_mask;
    logic [31:0] sti_data;
    logic        sti_valid;
    logic        sti_ready;
    logic [31:0] sto_data;
    logic        sto_valid;
    logic        sto_ready;
`ifdef SAMPLE_PACKER_LAST_EN
    logic        sto_last;
`endif

    int chk_cnt;
    int pass_cnt;
    logic [31:0] fr_vec [4];

    sample_packer #(.DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctl_clr   (ctl_clr),
        .ctl_ena   (ctl_ena),
        .ctl_flush (ctl_flush),
        .cfg_mask  (cfg_mask),
        .sti_data  (sti_data),
        .sti_valid (sti_valid),
        .sti_ready (sti_ready),
        .sto_data  (sto_data),
        .sto_valid (sto_valid),
`ifdef SAMPLE_PACKER_LAST_EN
        .sto_last  (sto_last),
`endif
        .sto_ready (sto_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr(input logic [3:0] m);
        cfg_mask = m;
        ctl_clr  = 1'b1;
        step();
        ctl_clr  = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        sti_data  = d;
        sti_valid = 1'b1;
        step();
        sti_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        chk_cnt++; if (sti_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", sti_ready); else pass_cnt++;
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", sto_valid); else pass_cnt++;
        chk_cnt++; if (sto_data !== 32'h0) $display("FAIL rst_data got %h exp 00000000", sto_data); else pass_cnt++;
`ifdef SAMPLE_PACKER_LAST_EN
        chk_cnt++; if (sto_last !== 1'b0) $display("FAIL rst_last got %b exp 0", sto_last); else pass_cnt++;
`endif
        step();
        step();
        rst = 1'b0;
        #1;
        chk_cnt++; if (sti_ready !== 1'b1) $display("FAIL post_rst_ready got %b exp 1", sti_ready); else pass_cnt++;
    endtask

    task automatic test_n1();
        clr(4'b0001);
        send(32'h11);
        send(32'h22);
        send(32'h33);
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL n1_early_valid got %b exp 0", sto_valid); else pass_cnt++;
        send(32'h44);
        chk_cnt++; if (sto_valid !== 1'b1) $display("FAIL n1_valid got %b exp 1", sto_valid); else pass_cnt++;
        chk_cnt++; if (sto_data !== 32'h44332211) $display("FAIL n1_data got %h exp 44332211", sto_data); else pass_cnt++;
        step();
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL n1_drain got %b exp 0", sto_valid); else pass_cnt++;
    endtask

    task automatic test_n3_flush();
        clr(4'b0111);
        send(32'h00CCBBAA);
        send(32'h00FFEEDD);
        chk_cnt++; if (sto_valid !== 1'b1) $display("FAIL n3_valid got %b exp 1", sto_valid); else pass_cnt++;
        chk_cnt++; if (sto_data !== 32'hDDCCBBAA) $display("FAIL n3_data got %h exp DDCCBBAA", sto_data); else pass_cnt++;
        ctl_flush = 1'b1;
        step();
        ctl_flush = 1'b0;
        sti_valid = 1'b1;
        #1;
        chk_cnt++; if (sti_ready !== 1'b0) $display("FAIL n3_flush_ready got %b exp 0", sti_ready); else pass_cnt++;
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL n3_flush_gap got %b exp 0", sto_valid); else pass_cnt++;
        sti_valid = 1'b0;
        step();
        chk_cnt++; if (sto_valid !== 1'b1) $display("FAIL n3_tail_valid got %b exp 1", sto_valid); else pass_cnt++;
        chk_cnt++; if (sto_data !== 32'h0000FFEE) $display("FAIL n3_tail_data got %h exp 0000FFEE", sto_data); else pass_cnt++;
`ifdef SAMPLE_PACKER_LAST_EN
        chk_cnt++; if (sto_last !== 1'b1) $display("FAIL n3_tail_last got %b exp 1", sto_last); else pass_cnt++;
`endif
        step();
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL n3_done_valid got %b exp 0", sto_valid); else pass_cnt++;
        sti_valid = 1'b1;
        #1;
        chk_cnt++; if (sti_ready !== 1'b0) $display("FAIL n3_done_ready got %b exp 0", sti_ready); else pass_cnt++;
        sti_valid = 1'b0;
    endtask

    task automatic test_full_rate();
        fr_vec[0] = 32'h12345678;
        fr_vec[1] = 32'h9ABCDEF0;
        fr_vec[2] = 32'h0F1E2D3C;
        fr_vec[3] = 32'hA5A55A5A;
        clr(4'b0000);
        for (int i = 0; i < 4; i++) begin
            sti_valid = 1'b1;
            sti_data  = fr_vec[i];
            step();
            chk_cnt++; if (sto_valid !== 1'b1) $display("FAIL fr_valid[%0d] got %b exp 1", i, sto_valid); else pass_cnt++;
            chk_cnt++; if (sto_data !== fr_vec[i]) $display("FAIL fr_data[%0d] got %h exp %h", i, sto_data, fr_vec[i]); else pass_cnt++;
        end
`ifdef SAMPLE_PACKER_LAST_EN
        chk_cnt++; if (sto_last !== 1'b0) $display("FAIL fr_last got %b exp 0", sto_last); else pass_cnt++;
`endif
        sto_ready = 1'b0;
        sti_data  = 32'hCAFEF00D;
        #1;
        chk_cnt++; if (sti_ready !== 1'b0) $display("FAIL bp_ready got %b exp 0", sti_ready); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_cnt++; if (sto_valid !== 1'b1 || sto_data !== fr_vec[3])
                $display("FAIL bp_hold[%0d] got %b/%h exp 1/%h", k, sto_valid, sto_data, fr_vec[3]); else pass_cnt++;
            chk_cnt++; if (sti_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b exp 0", k, sti_ready); else pass_cnt++;
        end
        sto_ready = 1'b1;
        #1;
        chk_cnt++; if (sti_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", sti_ready); else pass_cnt++;
        step();
        sti_valid = 1'b0;
        chk_cnt++; if (sto_data !== 32'hCAFEF00D) $display("FAIL bp_resume_data got %h exp CAFEF00D", sto_data); else pass_cnt++;
        step();
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", sto_valid); else pass_cnt++;
    endtask

    task automatic test_flush_same_cycle();
        clr(4'b0011);
        sti_data  = 32'h0000BBAA;
        sti_valid = 1'b1;
        ctl_flush = 1'b1;
        step();
        sti_valid = 1'b0;
        ctl_flush = 1'b0;
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL fs_gap got %b exp 0", sto_valid); else pass_cnt++;
        step();
        chk_cnt++; if (sto_valid !== 1'b1 || sto_data !== 32'h0000BBAA)
            $display("FAIL fs_word got %b/%h exp 1/0000BBAA", sto_valid, sto_data); else pass_cnt++;
        step();
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL fs_drain got %b exp 0", sto_valid); else pass_cnt++;
        clr(4'b0011);
        ctl_flush = 1'b1;
        step();
        ctl_flush = 1'b0;
        step();
`ifdef SAMPLE_PACKER_LAST_EN
        chk_cnt++; if (sto_valid !== 1'b1 || sto_data !== 32'h0 || sto_last !== 1'b1)
            $display("FAIL empty_flush got %b/%h/%b exp 1/00000000/1", sto_valid, sto_data, sto_last); else pass_cnt++;
`else
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL empty_flush got %b exp 0", sto_valid); else pass_cnt++;
`endif
        step();
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL empty_flush_after got %b exp 0", sto_valid); else pass_cnt++;
        sti_valid = 1'b1;
        #1;
        chk_cnt++; if (sti_ready !== 1'b0) $display("FAIL empty_flush_done_ready got %b exp 0", sti_ready); else pass_cnt++;
        sti_valid = 1'b0;
    endtask

    task automatic test_clear();
        clr(4'b0111);
        sto_ready = 1'b0;
        send(32'h00030201);
        send(32'h00060504);
        chk_cnt++; if (sto_valid !== 1'b1) $display("FAIL clr_pre_valid got %b exp 1", sto_valid); else pass_cnt++;
        clr(4'b0111);
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL clr_discard got %b exp 0", sto_valid); else pass_cnt++;
        sto_ready = 1'b1;
        send(32'h00030201);
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL clr_s1 got %b exp 0", sto_valid); else pass_cnt++;
        send(32'h00060504);
        chk_cnt++; if (sto_valid !== 1'b1 || sto_data !== 32'h04030201)
            $display("FAIL clr_w0 got %b/%h exp 1/04030201", sto_valid, sto_data); else pass_cnt++;
        send(32'h00090807);
        chk_cnt++; if (sto_valid !== 1'b1 || sto_data !== 32'h08070605)
            $display("FAIL clr_w1 got %b/%h exp 1/08070605", sto_valid, sto_data); else pass_cnt++;
        send(32'h000C0B0A);
        chk_cnt++; if (sto_valid !== 1'b1 || sto_data !== 32'h0C0B0A09)
            $display("FAIL clr_w2 got %b/%h exp 1/0C0B0A09", sto_valid, sto_data); else pass_cnt++;
        step();
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL clr_drain got %b exp 0", sto_valid); else pass_cnt++;
    endtask

    task automatic test_rst_ena();
        clr(4'b0001);
        send(32'hAA);
        send(32'hBB);
        ctl_ena   = 1'b0;
        sti_valid = 1'b1;
        sti_data  = 32'hEE;
        #1;
        chk_cnt++; if (sti_ready !== 1'b0) $display("FAIL ena_ready got %b exp 0", sti_ready); else pass_cnt++;
        step();
        step();
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL ena_valid got %b exp 0", sto_valid); else pass_cnt++;
        sti_valid = 1'b0;
        ctl_ena   = 1'b1;
        send(32'hCC);
        send(32'hDD);
        chk_cnt++; if (sto_valid !== 1'b1 || sto_data !== 32'hDDCCBBAA)
            $display("FAIL ena_word got %b/%h exp 1/DDCCBBAA", sto_valid, sto_data); else pass_cnt++;
        ctl_ena = 1'b0;
        step();
        step();
        chk_cnt++; if (sto_valid !== 1'b1 || sto_data !== 32'hDDCCBBAA)
            $display("FAIL ena_hold got %b/%h exp 1/DDCCBBAA", sto_valid, sto_data); else pass_cnt++;
        ctl_ena = 1'b1;
        step();
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL ena_release got %b exp 0", sto_valid); else pass_cnt++;
        send(32'h01);
        send(32'h02);
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++; if (sto_valid !== 1'b0 || sto_data !== 32'h0 || sti_ready !== 1'b0)
            $display("FAIL mid_rst got %b/%h/%b exp 0/00000000/0", sto_valid, sto_data, sti_ready); else pass_cnt++;
        step();
        rst = 1'b0;
        send(32'h11223344);
        chk_cnt++; if (sto_valid !== 1'b1 || sto_data !== 32'h11223344)
            $display("FAIL post_rst_word got %b/%h exp 1/11223344", sto_valid, sto_data); else pass_cnt++;
        step();
        chk_cnt++; if (sto_valid !== 1'b0) $display("FAIL post_rst_drain got %b exp 0", sto_valid); else pass_cnt++;
    endtask

    initial begin
        chk_cnt   = 0;
        pass_cnt  = 0;
        rst       = 1'b1;
        ctl_clr   = 1'b0;
        ctl_ena   = 1'b1;
        ctl_flush = 1'b0;
        cfg_mask  = 4'b0000;
        sti_data  = 32'h0;
        sti_valid = 1'b0;
        sto_ready = 1'b1;
        test_reset();
        test_n1();
        test_n3_flush();
        test_full_rate();
        test_flush_same_cycle();
        test_clear();
        test_rst_ena();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
